// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-side issue, register-file read, writeback snoop and
// downstream operand bundle of the operand fetch stage.
interface operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_src0;
  logic [2:0]  in_src1;
  logic [2:0]  in_dst;
  logic        in_wr;
  logic [2:0]  r_addr_0;
  logic [2:0]  r_addr_1;
  logic [31:0] r_val_0;
  logic [31:0] r_val_1;
  logic        wb_enable;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op0;
  logic [31:0] out_op1;
  logic [2:0]  out_dst;
  logic        out_wr;
  logic [7:0]  pending;

  modport master (
    output in_valid, in_src0, in_src1, in_dst, in_wr,
    output r_val_0, r_val_1,
    output wb_enable, wb_addr, wb_data,
    output out_ready,
    input  in_ready, r_addr_0, r_addr_1,
    input  out_valid, out_op0, out_op1, out_dst, out_wr,
    input  pending
  );

  modport slave (
    input  in_valid, in_src0, in_src1, in_dst, in_wr,
    input  r_val_0, r_val_1,
    input  wb_enable, wb_addr, wb_data,
    input  out_ready,
    output in_ready, r_addr_0, r_addr_1,
    output out_valid, out_op0, out_op1, out_dst, out_wr,
    output pending
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: register read, write scoreboard and one-entry operand bundle.
// Define OPERAND_FETCH_BYPASS_EN to forward snooped writeback data.
module operand_fetch (
  input logic            clk,
  input logic            rst_n,
  operand_fetch_if.slave bus
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] op0_q, op0_d;
  logic [31:0] op1_q, op1_d;
  logic [2:0]  dst_q, dst_d;
  logic        wr_q, wr_d;
  logic [7:0]  pending_q, pending_d;

  logic [7:0]  wb_mask;
  logic [7:0]  fwd_mask;
  logic [7:0]  busy;
  logic        fwd0, fwd1;
  logic        hazard;
  logic        accept;

  assign bus.r_addr_0 = bus.in_src0;
  assign bus.r_addr_1 = bus.in_src1;

  always_comb begin
    wb_mask = '0;
    if (bus.wb_enable) wb_mask[bus.wb_addr] = 1'b1;
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  assign fwd_mask = wb_mask;
  assign fwd0 = bus.wb_enable && (bus.wb_addr == bus.in_src0);
  assign fwd1 = bus.wb_enable && (bus.wb_addr == bus.in_src1);
`else
  assign fwd_mask = '0;
  assign fwd0 = 1'b0;
  assign fwd1 = 1'b0;
`endif

  // A register whose write lands this edge is free only when forwarded.
  assign busy = pending_q & ~fwd_mask;

  assign hazard = busy[bus.in_src0] ||
                  busy[bus.in_src1] ||
                  (bus.in_wr && busy[bus.in_dst]);

  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard;
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    op0_d       = op0_q;
    op1_d       = op1_q;
    dst_d       = dst_q;
    wr_d        = wr_q;
    pending_d   = pending_q;
    if (accept) begin
      out_valid_d = 1'b1;
      op0_d       = fwd0 ? bus.wb_data : bus.r_val_0;
      op1_d       = fwd1 ? bus.wb_data : bus.r_val_1;
      dst_d       = bus.in_dst;
      wr_d        = bus.in_wr;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (bus.wb_enable) pending_d[bus.wb_addr] = 1'b0;
    // Issuing a new writer of the same register outranks its retiring write.
    if (accept && bus.in_wr) pending_d[bus.in_dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op0_q       <= '0;
      op1_q       <= '0;
      dst_q       <= '0;
      wr_q        <= 1'b0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      dst_q       <= dst_d;
      wr_q        <= wr_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_op0   = op0_q;
  assign bus.out_op1   = op1_q;
  assign bus.out_dst   = dst_q;
  assign bus.out_wr    = wr_q;
  assign bus.pending   = pending_q;

endmodule
